// File: rtl/nasti_arb_pkg.sv
// Shared types and helpers for the two-master NASTI arbiter.
package nasti_arb_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ADDR = 1'b1
  } r_state_t;

  // Grant bit for a 2-way round-robin: a lone requester wins, a tie goes to prio.
  function automatic logic rr_pick(input logic prio, input logic req0, input logic req1);
    if (req0 && !req1) return 1'b0;
    if (req1 && !req0) return 1'b1;
    return prio;
  endfunction

endpackage

// File: rtl/nasti_rr_arb2.sv
// Registered 2-way round-robin picker. The grant is captured on load and held
// until the next load; priority moves to the other master once the granted
// request is accepted.
module nasti_rr_arb2
  import nasti_arb_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic req0,
  input  logic req1,
  input  logic load,
  input  logic accept,
  output logic gnt
);

  logic prio;

  // Capture the winner at the start of a transaction; hand priority over on accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt  <= 1'b0;
      prio <= 1'b0;
    end else begin
      // NOTE: non-blocking, so prio is updated from the grant held before this edge.
      if (load)   gnt  <= rr_pick(prio, req0, req1);
      if (accept) prio <= ~gnt;
    end
  end

endmodule

// File: rtl/nasti_arb2.sv
// Two-master to one-slave NASTI arbiter. AW and AR are arbitrated round-robin,
// a write burst owns the W channel from its AW until w_last, and B/R responses
// are steered back by the extra source bit at the top of the slave-side ID.
module nasti_arb2
  import nasti_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  // master 0
  input  logic                    m0_aw_valid,
  output logic                    m0_aw_ready,
  input  logic [ID_WIDTH-1:0]     m0_aw_id,
  input  logic [ADDR_WIDTH-1:0]   m0_aw_addr,
  input  logic [LEN_W-1:0]        m0_aw_len,
  input  logic [SIZE_W-1:0]       m0_aw_size,
  input  logic [BURST_W-1:0]      m0_aw_burst,
  input  logic [USER_WIDTH-1:0]   m0_aw_user,
  input  logic                    m0_w_valid,
  output logic                    m0_w_ready,
  input  logic [DATA_WIDTH-1:0]   m0_w_data,
  input  logic [DATA_WIDTH/8-1:0] m0_w_strb,
  input  logic                    m0_w_last,
  input  logic [USER_WIDTH-1:0]   m0_w_user,
  output logic                    m0_b_valid,
  input  logic                    m0_b_ready,
  output logic [ID_WIDTH-1:0]     m0_b_id,
  output logic [RESP_W-1:0]       m0_b_resp,
  output logic [USER_WIDTH-1:0]   m0_b_user,
  input  logic                    m0_ar_valid,
  output logic                    m0_ar_ready,
  input  logic [ID_WIDTH-1:0]     m0_ar_id,
  input  logic [ADDR_WIDTH-1:0]   m0_ar_addr,
  input  logic [LEN_W-1:0]        m0_ar_len,
  input  logic [SIZE_W-1:0]       m0_ar_size,
  input  logic [BURST_W-1:0]      m0_ar_burst,
  input  logic [USER_WIDTH-1:0]   m0_ar_user,
  output logic                    m0_r_valid,
  input  logic                    m0_r_ready,
  output logic [ID_WIDTH-1:0]     m0_r_id,
  output logic [DATA_WIDTH-1:0]   m0_r_data,
  output logic [RESP_W-1:0]       m0_r_resp,
  output logic                    m0_r_last,
  output logic [USER_WIDTH-1:0]   m0_r_user,
  // master 1
  input  logic                    m1_aw_valid,
  output logic                    m1_aw_ready,
  input  logic [ID_WIDTH-1:0]     m1_aw_id,
  input  logic [ADDR_WIDTH-1:0]   m1_aw_addr,
  input  logic [LEN_W-1:0]        m1_aw_len,
  input  logic [SIZE_W-1:0]       m1_aw_size,
  input  logic [BURST_W-1:0]      m1_aw_burst,
  input  logic [USER_WIDTH-1:0]   m1_aw_user,
  input  logic                    m1_w_valid,
  output logic                    m1_w_ready,
  input  logic [DATA_WIDTH-1:0]   m1_w_data,
  input  logic [DATA_WIDTH/8-1:0] m1_w_strb,
  input  logic                    m1_w_last,
  input  logic [USER_WIDTH-1:0]   m1_w_user,
  output logic                    m1_b_valid,
  input  logic                    m1_b_ready,
  output logic [ID_WIDTH-1:0]     m1_b_id,
  output logic [RESP_W-1:0]       m1_b_resp,
  output logic [USER_WIDTH-1:0]   m1_b_user,
  input  logic                    m1_ar_valid,
  output logic                    m1_ar_ready,
  input  logic [ID_WIDTH-1:0]     m1_ar_id,
  input  logic [ADDR_WIDTH-1:0]   m1_ar_addr,
  input  logic [LEN_W-1:0]        m1_ar_len,
  input  logic [SIZE_W-1:0]       m1_ar_size,
  input  logic [BURST_W-1:0]      m1_ar_burst,
  input  logic [USER_WIDTH-1:0]   m1_ar_user,
  output logic                    m1_r_valid,
  input  logic                    m1_r_ready,
  output logic [ID_WIDTH-1:0]     m1_r_id,
  output logic [DATA_WIDTH-1:0]   m1_r_data,
  output logic [RESP_W-1:0]       m1_r_resp,
  output logic                    m1_r_last,
  output logic [USER_WIDTH-1:0]   m1_r_user,
  // slave toward memory
  output logic                    s_aw_valid,
  input  logic                    s_aw_ready,
  output logic [ID_WIDTH:0]       s_aw_id,
  output logic [ADDR_WIDTH-1:0]   s_aw_addr,
  output logic [LEN_W-1:0]        s_aw_len,
  output logic [SIZE_W-1:0]       s_aw_size,
  output logic [BURST_W-1:0]      s_aw_burst,
  output logic [USER_WIDTH-1:0]   s_aw_user,
  output logic                    s_w_valid,
  input  logic                    s_w_ready,
  output logic [DATA_WIDTH-1:0]   s_w_data,
  output logic [DATA_WIDTH/8-1:0] s_w_strb,
  output logic                    s_w_last,
  output logic [USER_WIDTH-1:0]   s_w_user,
  input  logic                    s_b_valid,
  output logic                    s_b_ready,
  input  logic [ID_WIDTH:0]       s_b_id,
  input  logic [RESP_W-1:0]       s_b_resp,
  input  logic [USER_WIDTH-1:0]   s_b_user,
  output logic                    s_ar_valid,
  input  logic                    s_ar_ready,
  output logic [ID_WIDTH:0]       s_ar_id,
  output logic [ADDR_WIDTH-1:0]   s_ar_addr,
  output logic [LEN_W-1:0]        s_ar_len,
  output logic [SIZE_W-1:0]       s_ar_size,
  output logic [BURST_W-1:0]      s_ar_burst,
  output logic [USER_WIDTH-1:0]   s_ar_user,
  input  logic                    s_r_valid,
  output logic                    s_r_ready,
  input  logic [ID_WIDTH:0]       s_r_id,
  input  logic [DATA_WIDTH-1:0]   s_r_data,
  input  logic [RESP_W-1:0]       s_r_resp,
  input  logic                    s_r_last,
  input  logic [USER_WIDTH-1:0]   s_r_user
);

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  logic     wgnt, w_load, w_accept;
  logic     rgnt, r_load, r_accept;
  logic     b_sel, r_sel;

  nasti_rr_arb2 u_warb (
    .clk    (clk),
    .rstn   (rstn),
    .req0   (m0_aw_valid),
    .req1   (m1_aw_valid),
    .load   (w_load),
    .accept (w_accept),
    .gnt    (wgnt)
  );

  nasti_rr_arb2 u_rarb (
    .clk    (clk),
    .rstn   (rstn),
    .req0   (m0_ar_valid),
    .req1   (m1_ar_valid),
    .load   (r_load),
    .accept (r_accept),
    .gnt    (rgnt)
  );

  // Write FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  // Write FSM: grant, forward AW, then own W until the last beat.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt = w_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    s_aw_valid  = 1'b0;
    s_w_valid   = 1'b0;
    m0_aw_ready = 1'b0;
    m1_aw_ready = 1'b0;
    m0_w_ready  = 1'b0;
    m1_w_ready  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (m0_aw_valid || m1_aw_valid) begin
          w_load      = 1'b1;
          w_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        s_aw_valid  = wgnt ? m1_aw_valid : m0_aw_valid;
        m0_aw_ready = !wgnt && s_aw_ready;
        m1_aw_ready =  wgnt && s_aw_ready;
        if (s_aw_valid && s_aw_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        s_w_valid  = wgnt ? m1_w_valid : m0_w_valid;
        m0_w_ready = !wgnt && s_w_ready;
        m1_w_ready =  wgnt && s_w_ready;
        if (s_w_valid && s_w_ready && s_w_last) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  // Read FSM: grant, then forward AR until it is accepted.
  always_comb begin
    r_state_nxt = r_state;
    r_load      = 1'b0;
    r_accept    = 1'b0;
    s_ar_valid  = 1'b0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (m0_ar_valid || m1_ar_valid) begin
          r_load      = 1'b1;
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        s_ar_valid  = rgnt ? m1_ar_valid : m0_ar_valid;
        m0_ar_ready = !rgnt && s_ar_ready;
        m1_ar_ready =  rgnt && s_ar_ready;
        if (s_ar_valid && s_ar_ready) begin
          r_accept    = 1'b1;
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Request payloads follow the registered grant; the source bit tops the ID.
  assign s_aw_id    = wgnt ? {1'b1, m1_aw_id} : {1'b0, m0_aw_id};
  assign s_aw_addr  = wgnt ? m1_aw_addr  : m0_aw_addr;
  assign s_aw_len   = wgnt ? m1_aw_len   : m0_aw_len;
  assign s_aw_size  = wgnt ? m1_aw_size  : m0_aw_size;
  assign s_aw_burst = wgnt ? m1_aw_burst : m0_aw_burst;
  assign s_aw_user  = wgnt ? m1_aw_user  : m0_aw_user;
  assign s_w_data   = wgnt ? m1_w_data   : m0_w_data;
  assign s_w_strb   = wgnt ? m1_w_strb   : m0_w_strb;
  assign s_w_last   = wgnt ? m1_w_last   : m0_w_last;
  assign s_w_user   = wgnt ? m1_w_user   : m0_w_user;
  assign s_ar_id    = rgnt ? {1'b1, m1_ar_id} : {1'b0, m0_ar_id};
  assign s_ar_addr  = rgnt ? m1_ar_addr  : m0_ar_addr;
  assign s_ar_len   = rgnt ? m1_ar_len   : m0_ar_len;
  assign s_ar_size  = rgnt ? m1_ar_size  : m0_ar_size;
  assign s_ar_burst = rgnt ? m1_ar_burst : m0_ar_burst;
  assign s_ar_user  = rgnt ? m1_ar_user  : m0_ar_user;

  // Responses are steered by the source bit alone; rstn gating keeps the
  // master-facing handshakes quiet while reset is held.
  assign b_sel      = s_b_id[ID_WIDTH];
  assign m0_b_valid = rstn & s_b_valid & ~b_sel;
  assign m1_b_valid = rstn & s_b_valid &  b_sel;
  assign s_b_ready  = rstn & (b_sel ? m1_b_ready : m0_b_ready);
  assign m0_b_id    = s_b_id[ID_WIDTH-1:0];
  assign m1_b_id    = s_b_id[ID_WIDTH-1:0];
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;
  assign m0_b_user  = s_b_user;
  assign m1_b_user  = s_b_user;

  assign r_sel      = s_r_id[ID_WIDTH];
  assign m0_r_valid = rstn & s_r_valid & ~r_sel;
  assign m1_r_valid = rstn & s_r_valid &  r_sel;
  assign s_r_ready  = rstn & (r_sel ? m1_r_ready : m0_r_ready);
  assign m0_r_id    = s_r_id[ID_WIDTH-1:0];
  assign m1_r_id    = s_r_id[ID_WIDTH-1:0];
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;
  assign m0_r_user  = s_r_user;
  assign m1_r_user  = s_r_user;

endmodule

// File: doc/nasti_arb2.md
# nasti_arb2

Two-master to one-slave NASTI arbiter placed in front of the shared memory model (or on-chip RAM) port. It lets two requesters, for example the core L2 port and a debug/DMA port, share a single memory slave. It arbitrates AW and AR round-robin and keeps each write burst atomic on the W channel. Responses are routed back to the issuing master by an extra ID bit appended on the slave side.

## Interface
- ID_WIDTH, 1: master-side ID width; slave-side ID width is ID_WIDTH+1.
- ADDR_WIDTH, 16: address width, same on all ports.
- DATA_WIDTH, 128: data width; W strobe width is DATA_WIDTH/8.
- USER_WIDTH, 1: user field width, passed through unchanged.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- m0  nasti_channel.slave  —  master 0 port (ID_WIDTH IDs); wins ties after reset.
- m1  nasti_channel.slave  —  master 1 port (ID_WIDTH IDs).
- s  nasti_channel.master  —  slave port toward memory (ID_WIDTH+1 IDs).

## Operation
- Slave-side ID is {src, master_id}, where src is 0 for m0 and 1 for m1.
- B and R responses are routed by s.b_id[ID_WIDTH] and s.r_id[ID_WIDTH]. Routing is purely combinational.
- The routed valid goes to the selected master only. s.b_ready and s.r_ready are driven from the selected master's ready.
- Response IDs are truncated to ID_WIDTH bits toward the master.
- Write FSM has three states: W_IDLE, W_ADDR, W_DATA.
  - W_IDLE: if any aw_valid is high, register wgnt using round-robin, then go to W_ADDR.
  - W_ADDR: drive s.aw_* from the wgnt master. On s.aw_valid && s.aw_ready, go to W_DATA.
  - W_DATA: forward W from the wgnt master. On a w handshake with w_last=1, go to W_IDLE.
- Only one write burst is in flight on AW/W at a time. Outstanding B responses are unlimited.
- Read FSM has two states: R_IDLE, R_ADDR.
  - R_IDLE: if any ar_valid is high, register rgnt using round-robin, then go to R_ADDR.
  - R_ADDR: forward AR from the rgnt master. On handshake, go to R_IDLE.
- Multiple reads may be outstanding, since R routing depends only on ID.
- Round-robin rule: separate write and read priority bits, both reset to 0 (favouring m0).
  - After a granted AW or AR handshake, the corresponding priority bit points at the other master.
  - A lone requester always wins.
- Signals toward non-granted masters:
  - aw_ready, w_ready and ar_ready are forced to 0.
  - s.aw_valid, s.w_valid and s.ar_valid are 0 outside W_ADDR, W_DATA and R_ADDR respectively.
- W data arriving before its AW is granted is held off: w_ready stays 0 until W_DATA for that master.

## Timing
- Reset values: all FSMs idle; wgnt=rgnt=0; priority bits 0.
- Reset values of outputs: every valid and ready driven to the masters is 0; s.aw_valid, s.w_valid and s.ar_valid are 0.
- Reset mid-burst returns the block to idle immediately. Any partial burst is abandoned.
- Arbitration adds 1 cycle: a request seen in the idle state reaches s.*_valid on the next rising edge.
- B and R paths add 0 cycles (combinational).
- AXI rules: valid must not depend on ready. Once s.*_valid rises, payload and valid stay stable until the handshake, because the grant is registered and the master holds its request.
- Simultaneous B for m0 and R for m1 in one cycle are independent; both complete.
- Zero-wait throughput:
  - Back-to-back single-beat writes: one per 3 cycles (IDLE, ADDR, DATA).
  - Reads: one AR per 2 cycles.

## Structure
- A shared package nasti_arb_pkg holds:
  - the state enums (w_state_t, r_state_t);
  - a function rr_pick(prio, req0, req1) returning the grant bit.
- A natural sub-module is nasti_rr_arb2: a registered 2-way round-robin picker with a priority update on accept. It is instantiated once for writes and once for reads.
- Mux and demux logic stays in the top module.

## Test plan
- Reset with m0 and m1 both raising aw_valid, 4-beat bursts -> m0 burst on s first with aw_id=0_x; then m1 with aw_id=1_x. W beats never interleave.
- m1 ar_valid, addr 0x100, id 1 -> s.ar_id=2'b11 one cycle later. R responses with r_id=2'b11 appear only on m1 with id 1; m0.r_valid stays 0.
- Continuous AR from both masters for 8 grants -> strict alternation m0, m1, m0, ...
- m0 asserts w_valid 3 cycles before aw_valid -> m0.w_ready=0 until W_DATA; data is delivered intact.
- rstn pulled low after beat 2 of a 4-beat write -> all valids and readys are 0 asynchronously. After release, the FSM is in W_IDLE and a new m1 write completes.
- s returns B for id 2'b10 while R for id 2'b01 is in flight -> m1.b_valid and m0.r_valid are high in the same cycle; both complete with their own readys.
